mrd_frame_demux_in1out2: RTL and testbench

Frame-aware 1-to-2 demultiplexer for the `mrd_st_if` streaming interface. It steers whole DFT frames (sop..eop) from one upstream source to one of two downstream consumers, such as two parallel DFT engines. Steering is either fixed by a select input or ping-pong alternating. It never splits a frame, and it registers each output port so that downstream timing is isolated from upstream.

---
 rtl/mrd_frame_demux_in1out2_if.sv | 38 +++
 rtl/mrd_frame_demux_in1out2.sv | 166 ++++++++++++++++
 tb/tb_mrd_frame_demux_in1out2.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mrd_frame_demux_in1out2_if.sv
// Beat payload type and the mrd_st_if valid/ready streaming interface.
// All payload fields travel as one packed beat through the output stages.
package mrd_st_pkg;
  localparam int DW = 16;
  localparam int NW = 12;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] d_real;
    logic [DW-1:0] d_imag;
    logic [NW-1:0] dftpts;
    logic          inverse;
  } st_beat_t;
endpackage

interface mrd_st_if;
  import mrd_st_pkg::*;

  logic          valid;
  logic          ready;
  logic          sop;
  logic          eop;
  logic [DW-1:0] d_real;
  logic [DW-1:0] d_imag;
  logic [NW-1:0] dftpts;
  logic          inverse;

  modport ST_IN (
    input  valid, sop, eop, d_real, d_imag, dftpts, inverse,
    output ready
  );

  modport ST_OUT (
    output valid, sop, eop, d_real, d_imag, dftpts, inverse,
    input  ready
  );
endinterface

// File: rtl/mrd_frame_demux_in1out2.sv
// Frame-aware 1-to-2 stream demux: whole sop..eop frames go to one port,
// chosen by sw (fixed) or alternating (ping-pong), with registered outputs.
module mrd_frame_demux_in1out2
  import mrd_st_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             sw,
  mrd_st_if.ST_IN          in_data,
  mrd_st_if.ST_OUT         out_data_0,
  mrd_st_if.ST_OUT         out_data_1,
  output logic             busy,
  output logic             cur_port,
  output logic [CNT_W-1:0] frame_cnt_0,
  output logic [CNT_W-1:0] frame_cnt_1,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_sop
);

  typedef enum logic [1:0] {
    IDLE,
    FRAME0,
    FRAME1
  } state_t;

  state_t   state, state_nx;
  logic     np, np_nx;
  logic     v0, v1;
  st_beat_t p0, p1, beat;
  logic     can0, can1, tgt;
  logic     rdy, acc;
  logic     ld0, ld1;
  logic     fc0_inc, fc1_inc, drop_inc, err_nx;

  assign beat = {in_data.sop, in_data.eop,
                 in_data.d_real, in_data.d_imag,
                 in_data.dftpts, in_data.inverse};

  assign can0 = !v0 || out_data_0.ready;
  assign can1 = !v1 || out_data_1.ready;
  assign tgt  = mode ? np : sw;

  // Stray beats in IDLE are always taken so they cannot stall the source.
  always_comb begin
    rdy = 1'b0;
    unique case (state)
      IDLE:    rdy = (in_data.valid && !in_data.sop) ||
                     (tgt ? can1 : can0);
      FRAME0:  rdy = can0;
      FRAME1:  rdy = can1;
      default: rdy = 1'b0;
    endcase
    if (rst) rdy = 1'b0;
  end

  assign in_data.ready = rdy;
  assign acc = in_data.valid && rdy;

  always_comb begin
    state_nx = state;
    np_nx    = np;
    ld0      = 1'b0;
    ld1      = 1'b0;
    fc0_inc  = 1'b0;
    fc1_inc  = 1'b0;
    drop_inc = 1'b0;
    err_nx   = 1'b0;
    if (acc) begin
      unique case (state)
        IDLE: begin
          if (!in_data.sop) begin
            drop_inc = 1'b1;
          end else begin
            ld0 = !tgt;
            ld1 = tgt;
            if (in_data.eop) begin
              fc0_inc = !tgt;
              fc1_inc = tgt;
              if (mode) np_nx = !np;
            end else begin
              state_nx = tgt ? FRAME1 : FRAME0;
            end
          end
        end
        FRAME0, FRAME1: begin
          ld0    = (state == FRAME0);
          ld1    = (state == FRAME1);
          err_nx = in_data.sop;
          if (in_data.eop) begin
            fc0_inc  = (state == FRAME0);
            fc1_inc  = (state == FRAME1);
            state_nx = IDLE;
            if (mode) np_nx = !np;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      np          <= 1'b0;
      frame_cnt_0 <= '0;
      frame_cnt_1 <= '0;
      drop_cnt    <= '0;
      err_sop     <= 1'b0;
    end else begin
      state   <= state_nx;
      np      <= np_nx;
      err_sop <= err_nx;
      if (fc0_inc)  frame_cnt_0 <= frame_cnt_0 + CNT_W'(1);
      if (fc1_inc)  frame_cnt_1 <= frame_cnt_1 + CNT_W'(1);
      if (drop_inc) drop_cnt    <= drop_cnt + CNT_W'(1);
    end
  end

  // A load in the same cycle as a drain replaces the beat, valid stays up.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      p0 <= '0;
    end else if (ld0) begin
      v0 <= 1'b1;
      p0 <= beat;
    end else if (out_data_0.ready) begin
      v0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      p1 <= '0;
    end else if (ld1) begin
      v1 <= 1'b1;
      p1 <= beat;
    end else if (out_data_1.ready) begin
      v1 <= 1'b0;
    end
  end

  assign out_data_0.valid   = v0;
  assign out_data_0.sop     = p0.sop;
  assign out_data_0.eop     = p0.eop;
  assign out_data_0.d_real  = p0.d_real;
  assign out_data_0.d_imag  = p0.d_imag;
  assign out_data_0.dftpts  = p0.dftpts;
  assign out_data_0.inverse = p0.inverse;

  assign out_data_1.valid   = v1;
  assign out_data_1.sop     = p1.sop;
  assign out_data_1.eop     = p1.eop;
  assign out_data_1.d_real  = p1.d_real;
  assign out_data_1.d_imag  = p1.d_imag;
  assign out_data_1.dftpts  = p1.dftpts;
  assign out_data_1.inverse = p1.inverse;

  assign busy     = (state != IDLE);
  assign cur_port = (state == IDLE) ? tgt : (state == FRAME1);

endmodule

// File: tb/tb_mrd_frame_demux_in1out2.sv
// Directed bench for mrd_frame_demux_in1out2: routing, backpressure,
// stray beats, single-beat frames, sop-in-frame error and reset.
module tb_mrd_frame_demux_in1out2;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [15:0] re;
    logic [15:0] im;
    logic [11:0] pts;
    logic        inv;
    int          cyc;
  } rec_t;

  logic        clk, rst, mode, sw;
  logic        busy, cur_port, err_sop;
  logic [15:0] fc0, fc1, drop;
  logic        r0, r1, tog, bp_en;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   errs = 0;
  rec_t q0[$];
  rec_t q1[$];
  int   qa[$];

  mrd_st_if in_if ();
  mrd_st_if o0_if ();
  mrd_st_if o1_if ();

  assign o0_if.ready = bp_en ? tog : r0;
  assign o1_if.ready = r1;

  mrd_frame_demux_in1out2 #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .sw          (sw),
    .in_data     (in_if),
    .out_data_0  (o0_if),
    .out_data_1  (o1_if),
    .busy        (busy),
    .cur_port    (cur_port),
    .frame_cnt_0 (fc0),
    .frame_cnt_1 (fc1),
    .drop_cnt    (drop),
    .err_sop     (err_sop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp_en) tog = ~tog;
  end

  always @(negedge clk) begin
    if (o0_if.valid && o0_if.ready)
      q0.push_back('{o0_if.sop, o0_if.eop, o0_if.d_real, o0_if.d_imag,
                     o0_if.dftpts, o0_if.inverse, cyc});
    if (o1_if.valid && o1_if.ready)
      q1.push_back('{o1_if.sop, o1_if.eop, o1_if.d_real, o1_if.d_imag,
                     o1_if.dftpts, o1_if.inverse, cyc});
    if (in_if.valid && in_if.ready) qa.push_back(cyc);
    if (err_sop === 1'b1) errs++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
    qa.delete();
  endtask

  task automatic drive(input logic s, input logic e, input logic [15:0] tag);
    bit ok;
    in_if.valid   = 1'b1;
    in_if.sop     = s;
    in_if.eop     = e;
    in_if.d_real  = tag;
    in_if.d_imag  = ~tag;
    in_if.dftpts  = tag[11:0];
    in_if.inverse = tag[0];
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_if.ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL drive_timeout: beat %0h not accepted in 100 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 1'b1;
    sw = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    in_if.valid = 1'b1;
    in_if.sop = 1'b1;
    in_if.eop = 1'b0;
    in_if.d_real = 16'h55;
    in_if.d_imag = 16'h66;
    in_if.dftpts = 12'h0;
    in_if.inverse = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_if.ready !== 1'b0)
      $display("FAIL rst_ready: got %b want 0", in_if.ready);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_if.valid = 1'b0;
    total++;
    if (o0_if.valid !== 1'b0 || o1_if.valid !== 1'b0)
      $display("FAIL rst_valid: got %b%b want 00", o0_if.valid, o1_if.valid);
    else passed++;
    total++;
    if (o0_if.d_real !== 16'h0 || o1_if.d_imag !== 16'h0)
      $display("FAIL rst_payload: got %h %h want 0 0", o0_if.d_real, o1_if.d_imag);
    else passed++;
    total++;
    if (busy !== 1'b0 || err_sop !== 1'b0 || cur_port !== 1'b0)
      $display("FAIL rst_flags: busy/err/port got %b%b%b want 000", busy, err_sop, cur_port);
    else passed++;
    total++;
    if (fc0 !== 16'd0 || fc1 !== 16'd0 || drop !== 16'd0)
      $display("FAIL rst_cnt: got %0d %0d %0d want 0 0 0", fc0, fc1, drop);
    else passed++;
    mode = 1'b0;
    sw = 1'b1;
    #1;
    total++;
    if (cur_port !== 1'b1)
      $display("FAIL rst_cur_port_fixed: got %b want 1", cur_port);
    else passed++;
    mode = 1'b1;
    sw = 1'b0;
    idle(1);
  endtask

  task automatic test_ping_pong();
    logic [15:0] tag;
    rec_t r;
    int   k, bad;
    mode = 1'b1;
    clear_q();
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 8; b++)
        drive(b == 0, b == 7, 16'(f * 16 + b));
    idle(3);
    total++;
    if (q0.size() != 16 || q1.size() != 16 || qa.size() != 32)
      $display("FAIL pp_sizes: got %0d %0d %0d want 16 16 32", q0.size(), q1.size(), qa.size());
    else passed++;
    bad = 0;
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 8; b++) begin
        k = (f / 2) * 8 + b;
        tag = 16'(f * 16 + b);
        if ((f % 2) == 0 && k < q0.size()) r = q0[k];
        else if ((f % 2) == 1 && k < q1.size()) r = q1[k];
        else r = '{1'bx, 1'bx, 16'hx, 16'hx, 12'hx, 1'bx, -1};
        if (r.re !== tag || r.im !== ~tag || r.pts !== tag[11:0] ||
            r.inv !== tag[0] || r.sop !== (b == 0) || r.eop !== (b == 7))
          bad++;
        else if (f * 8 + b < qa.size() && r.cyc != qa[f * 8 + b] + 1)
          bad++;
      end
    total++;
    if (bad != 0)
      $display("FAIL pp_beats: got %0d bad beats want 0", bad);
    else passed++;
    total++;
    if (qa.size() == 32 && qa[31] - qa[0] != 31)
      $display("FAIL pp_gapless: got span %0d want 31", qa[31] - qa[0]);
    else passed++;
    total++;
    if (fc0 !== 16'd2 || fc1 !== 16'd2)
      $display("FAIL pp_cnt: got %0d %0d want 2 2", fc0, fc1);
    else passed++;
  endtask

  task automatic test_fixed_sw();
    int bad;
    mode = 1'b0;
    clear_q();
    for (int b = 0; b < 16; b++) begin
      if (b == 0) sw = 1'b1;
      if (b == 5) sw = 1'b0;
      drive(b == 0, b == 15, 16'(16'h100 + b));
      if (b == 8) begin
        total++;
        if (busy !== 1'b1 || cur_port !== 1'b1)
          $display("FAIL fx_mid: busy/port got %b%b want 11", busy, cur_port);
        else passed++;
      end
    end
    idle(3);
    total++;
    if (q1.size() != 16 || q0.size() != 0)
      $display("FAIL fx_route: got p0=%0d p1=%0d want 0 16", q0.size(), q1.size());
    else passed++;
    bad = 0;
    foreach (q1[i]) if (q1[i].re !== 16'(16'h100 + i)) bad++;
    total++;
    if (bad != 0)
      $display("FAIL fx_order: got %0d bad beats want 0", bad);
    else passed++;
    for (int b = 0; b < 4; b++) drive(b == 0, b == 3, 16'(16'h120 + b));
    idle(3);
    total++;
    if (q0.size() != 4 || q1.size() != 16)
      $display("FAIL fx_next: got p0=%0d p1=%0d want 4 16", q0.size(), q1.size());
    else passed++;
    total++;
    if (fc0 !== 16'd3 || fc1 !== 16'd3)
      $display("FAIL fx_cnt: got %0d %0d want 3 3", fc0, fc1);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    mode = 1'b1;
    clear_q();
    r1 = 1'b0;
    tog = 1'b1;
    bp_en = 1'b1;
    for (int b = 0; b < 4; b++) drive(b == 0, b == 3, 16'(16'h200 + b));
    drive(1'b1, 1'b0, 16'h210);
    in_if.valid = 1'b1;
    in_if.sop = 1'b0;
    in_if.d_real = 16'h211;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (in_if.ready !== 1'b0)
        $display("FAIL bp_stall%0d: ready got %b want 0", i, in_if.ready);
      else passed++;
    end
    total++;
    if (q1.size() != 0)
      $display("FAIL bp_held: got %0d beats on p1 want 0", q1.size());
    else passed++;
    @(posedge clk);
    #1;
    r1 = 1'b1;
    drive(1'b0, 1'b0, 16'h211);
    drive(1'b0, 1'b0, 16'h212);
    drive(1'b0, 1'b1, 16'h213);
    idle(4);
    bp_en = 1'b0;
    r0 = 1'b1;
    idle(1);
    bad = 0;
    foreach (q0[i]) if (q0[i].re !== 16'(16'h200 + i)) bad++;
    foreach (q1[i]) if (q1[i].re !== 16'(16'h210 + i)) bad++;
    total++;
    if (q0.size() != 4 || q1.size() != 4 || bad != 0)
      $display("FAIL bp_order: got p0=%0d p1=%0d bad=%0d want 4 4 0", q0.size(), q1.size(), bad);
    else passed++;
    total++;
    if (fc0 !== 16'd4 || fc1 !== 16'd4)
      $display("FAIL bp_cnt: got %0d %0d want 4 4", fc0, fc1);
    else passed++;
  endtask

  task automatic test_stray_single();
    mode = 1'b1;
    clear_q();
    for (int b = 0; b < 3; b++) drive(1'b0, b == 2, 16'(16'h2f0 + b));
    idle(2);
    total++;
    if (drop !== 16'd3 || q0.size() != 0 || q1.size() != 0)
      $display("FAIL stray: drop=%0d p0=%0d p1=%0d want 3 0 0", drop, q0.size(), q1.size());
    else passed++;
    drive(1'b1, 1'b1, 16'h300);
    idle(2);
    total++;
    if (q0.size() != 1 || busy !== 1'b0 || fc0 !== 16'd5)
      $display("FAIL single0: p0=%0d busy=%b fc0=%0d want 1 0 5", q0.size(), busy, fc0);
    else passed++;
    total++;
    if (q0.size() == 1 && (q0[0].re !== 16'h300 || q0[0].sop !== 1'b1 || q0[0].eop !== 1'b1))
      $display("FAIL single0_beat: got %h sop=%b eop=%b want 300 1 1", q0[0].re, q0[0].sop, q0[0].eop);
    else passed++;
    drive(1'b1, 1'b1, 16'h301);
    idle(2);
    total++;
    if (q1.size() != 1 || fc1 !== 16'd5)
      $display("FAIL single1: p1=%0d fc1=%0d want 1 5", q1.size(), fc1);
    else passed++;
  endtask

  task automatic test_err_reset();
    mode = 1'b1;
    clear_q();
    errs = 0;
    for (int b = 0; b < 5; b++) drive(b == 0 || b == 3, 1'b0, 16'(16'h400 + b));
    r0 = 1'b0;
    total++;
    if (errs != 1 || busy !== 1'b1)
      $display("FAIL err_pulse: pulses=%0d busy=%b want 1 1", errs, busy);
    else passed++;
    total++;
    if (q0.size() != 4 || q1.size() != 0 || (q0.size() == 4 && (q0[3].sop !== 1'b1 || q0[3].re !== 16'h403)))
      $display("FAIL err_route: p0=%0d p1=%0d want 4 0 with sop beat 403", q0.size(), q1.size());
    else passed++;
    in_if.valid = 1'b1;
    in_if.sop = 1'b0;
    in_if.d_real = 16'h405;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_if.ready !== 1'b0)
      $display("FAIL mid_rst_ready: got %b want 0", in_if.ready);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_if.valid = 1'b0;
    total++;
    if (o0_if.valid !== 1'b0 || o0_if.d_real !== 16'h0 || busy !== 1'b0 || err_sop !== 1'b0)
      $display("FAIL mid_rst_out: v=%b d=%h busy=%b err=%b want 0 0 0 0", o0_if.valid, o0_if.d_real, busy, err_sop);
    else passed++;
    total++;
    if (fc0 !== 16'd0 || fc1 !== 16'd0 || drop !== 16'd0 || cur_port !== 1'b0)
      $display("FAIL mid_rst_cnt: %0d %0d %0d port=%b want 0 0 0 0", fc0, fc1, drop, cur_port);
    else passed++;
    r0 = 1'b1;
    drive(1'b1, 1'b1, 16'h410);
    idle(2);
    total++;
    if (q0.size() != 5 || q1.size() != 0 || fc0 !== 16'd1)
      $display("FAIL post_rst: p0=%0d p1=%0d fc0=%0d want 5 0 1", q0.size(), q1.size(), fc0);
    else passed++;
    total++;
    if (q0.size() == 5 && q0[4].re !== 16'h410)
      $display("FAIL post_rst_beat: got %h want 410", q0[4].re);
    else passed++;
  endtask

  initial begin
    bp_en = 1'b0;
    tog = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    test_reset();
    test_ping_pong();
    test_fixed_sw();
    test_backpressure();
    test_stray_single();
    test_err_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
